// File: rtl/pomo_sequencer.sv
// Pomodoro session controller: sequences work / short-break / long-break phases,
// loads BCD durations into the countdown, and drives run, alarm and blink.
// Optional build macro POMO_AUTO_START_EN: after an alarm expiry the next phase starts
// counting on its own. When the macro is absent, the next phase waits in PAUSE.
module pomo_sequencer #(
    parameter int CLK_HZ       = 100000000,
    parameter int WORK_MIN     = 25,
    parameter int SHORT_MIN    = 5,
    parameter int LONG_MIN     = 15,
    parameter int LONG_EVERY   = 4,
    parameter int BLINK_DIV    = CLK_HZ / 4,
    parameter int ALARM_CYCLES = 2 * CLK_HZ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lever,
    input  logic       button,
    input  logic       timer_done,
    output logic       load,
    output logic [7:0] load_min_bcd,
    output logic       run,
    output logic [1:0] phase,
    output logic [2:0] pomo_count,
    output logic       alarm,
    output logic       blink
);

    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int ALARM_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_CYCLES - 1);
    localparam logic [2:0]         LONG_COUNT = 3'(LONG_EVERY);

    localparam logic [7:0] WORK_BCD  = {4'(WORK_MIN / 10),  4'(WORK_MIN % 10)};
    localparam logic [7:0] SHORT_BCD = {4'(SHORT_MIN / 10), 4'(SHORT_MIN % 10)};
    localparam logic [7:0] LONG_BCD  = {4'(LONG_MIN / 10),  4'(LONG_MIN % 10)};

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_WORK  = 2'd1;
    localparam logic [1:0] PH_SHORT = 2'd2;
    localparam logic [1:0] PH_LONG  = 2'd3;

    // An alarm that times out unattended either starts the next phase or parks it.
`ifdef POMO_AUTO_START_EN
    localparam logic EXPIRY_PAUSES = 1'b0;
`else
    localparam logic EXPIRY_PAUSES = 1'b1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_ALARM
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic [2:0]         pomo_q, pomo_d;
    logic               pause_after_load_q, pause_after_load_d;
    logic [ALARM_W-1:0] alarm_cnt_q, alarm_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic               load_q, load_d;
    logic [7:0]         bcd_q, bcd_d;
    logic               run_q, run_d;
    logic               alarm_q, alarm_d;
    logic               advance;

    function automatic logic [7:0] phase_bcd(input logic [1:0] ph);
        logic [7:0] val;
        case (ph)
            PH_WORK:  val = WORK_BCD;
            PH_SHORT: val = SHORT_BCD;
            PH_LONG:  val = LONG_BCD;
            default:  val = 8'h00;
        endcase
        return val;
    endfunction

    always_comb begin
        state_d            = state_q;
        phase_d            = phase_q;
        pomo_d             = pomo_q;
        pause_after_load_d = pause_after_load_q;
        alarm_cnt_d        = '0;
        advance            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (lever) begin
                    phase_d            = PH_WORK;
                    pause_after_load_d = 1'b0;
                    state_d            = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d            = pause_after_load_q ? S_PAUSE : S_RUN;
                pause_after_load_d = 1'b0;
            end
            S_RUN: begin
                if (timer_done) begin
                    state_d = S_ALARM;
                    if (phase_q == PH_WORK) begin
                        pomo_d = pomo_q + 3'd1;
                    end
                end else if (button) begin
                    advance = 1'b1;
                end else if (lever) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (button) begin
                    advance = 1'b1;
                end else if (lever) begin
                    state_d = S_RUN;
                end
            end
            S_ALARM: begin
                if (lever || button) begin
                    advance            = 1'b1;
                    pause_after_load_d = 1'b0;
                end else if (alarm_cnt_q == ALARM_LAST) begin
                    advance            = 1'b1;
                    pause_after_load_d = EXPIRY_PAUSES;
                end else begin
                    alarm_cnt_d = alarm_cnt_q + ALARM_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A skipped work phase never reaches LONG_COUNT, so it always lands on a short break.
        if (advance) begin
            state_d = S_LOAD;
            if (phase_q == PH_WORK) begin
                if (pomo_q == LONG_COUNT) begin
                    phase_d = PH_LONG;
                    pomo_d  = 3'd0;
                end else begin
                    phase_d = PH_SHORT;
                end
            end else begin
                phase_d = PH_WORK;
            end
        end
    end

    always_comb begin
        load_d      = (state_d == S_LOAD);
        run_d       = (state_d == S_RUN);
        alarm_d     = (state_d == S_ALARM);
        bcd_d       = load_d ? phase_bcd(phase_d) : bcd_q;
        blink_cnt_d = '0;
        blink_d     = 1'b0;

        // Blink restarts from the unblanked phase whenever PAUSE or ALARM is freshly entered.
        if ((state_d == S_PAUSE || state_d == S_ALARM) && state_d == state_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                blink_d     = blink_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= S_IDLE;
            phase_q            <= PH_IDLE;
            pomo_q             <= 3'd0;
            pause_after_load_q <= 1'b0;
            alarm_cnt_q        <= '0;
            blink_cnt_q        <= '0;
            blink_q            <= 1'b0;
            load_q             <= 1'b0;
            bcd_q              <= 8'h00;
            run_q              <= 1'b0;
            alarm_q            <= 1'b0;
        end else begin
            state_q            <= state_d;
            phase_q            <= phase_d;
            pomo_q             <= pomo_d;
            pause_after_load_q <= pause_after_load_d;
            alarm_cnt_q        <= alarm_cnt_d;
            blink_cnt_q        <= blink_cnt_d;
            blink_q            <= blink_d;
            load_q             <= load_d;
            bcd_q              <= bcd_d;
            run_q              <= run_d;
            alarm_q            <= alarm_d;
        end
    end

    assign load         = load_q;
    assign load_min_bcd = bcd_q;
    assign run          = run_q;
    assign phase        = phase_q;
    assign pomo_count   = pomo_q;
    assign alarm        = alarm_q;
    assign blink        = blink_q;

endmodule

// File: tb/tb_pomo_sequencer.sv
// Directed bench for pomo_sequencer: expected load transactions are queued by the stimulus
// and checked by an independent monitor; level outputs are checked in line.
module tb_pomo_sequencer;

    logic       clk;
    logic       rst;
    logic       lever;
    logic       button;
    logic       timer_done;
    logic       load;
    logic [7:0] load_min_bcd;
    logic       run;
    logic [1:0] phase;
    logic [2:0] pomo_count;
    logic       alarm;
    logic       blink;

    typedef struct packed {
        logic [7:0] bcd;
        logic [1:0] ph;
        logic [2:0] cnt;
    } load_exp_t;

    load_exp_t sb_q[$];
    int        compared   = 0;
    int        mismatched = 0;

    pomo_sequencer #(
        .WORK_MIN    (25),
        .SHORT_MIN   (5),
        .LONG_MIN    (15),
        .LONG_EVERY  (2),
        .BLINK_DIV   (4),
        .ALARM_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lever       (lever),
        .button      (button),
        .timer_done  (timer_done),
        .load        (load),
        .load_min_bcd(load_min_bcd),
        .run         (run),
        .phase       (phase),
        .pomo_count  (pomo_count),
        .alarm       (alarm),
        .blink       (blink)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle pulse on the chosen inputs; returns 1 ns after the edge that sampled it.
    task automatic applyStimulus(input logic lv, input logic bt, input logic td);
        lever      = lv;
        button     = bt;
        timer_done = td;
        @(posedge clk);
        #1;
        lever      = 1'b0;
        button     = 1'b0;
        timer_done = 1'b0;
    endtask

    task automatic expectLoad(input logic [7:0] bcd, input logic [1:0] ph, input logic [2:0] cnt);
        load_exp_t e;
        e.bcd = bcd;
        e.ph  = ph;
        e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    // Monitor: every load pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && load) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_load", {24'd0, load_min_bcd}, 32'hFFFF_FFFF);
            end else begin
                load_exp_t e;
                e = sb_q.pop_front();
                checkOutput("load_bcd", {24'd0, load_min_bcd}, {24'd0, e.bcd});
                checkOutput("load_phase", {30'd0, phase}, {30'd0, e.ph});
                checkOutput("load_pomo", {29'd0, pomo_count}, {29'd0, e.cnt});
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_load"}, {31'd0, load}, 32'd0);
        checkOutput({tag, "_bcd"}, {24'd0, load_min_bcd}, 32'h00);
        checkOutput({tag, "_run"}, {31'd0, run}, 32'd0);
        checkOutput({tag, "_phase"}, {30'd0, phase}, 32'd0);
        checkOutput({tag, "_pomo"}, {29'd0, pomo_count}, 32'd0);
        checkOutput({tag, "_alarm"}, {31'd0, alarm}, 32'd0);
        checkOutput({tag, "_blink"}, {31'd0, blink}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        lever      = 1'b0;
        button     = 1'b0;
        timer_done = 1'b0;
        cycle(3);
        checkResetState("reset");
        rst = 1'b0;
        cycle(2);

        // IDLE ignores done and skip pulses.
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("idle_phase", {30'd0, phase}, 32'd0);
        checkOutput("idle_load", {31'd0, load}, 32'd0);

        // Start a work session.
        expectLoad(8'h25, 2'd1, 3'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("start_load", {31'd0, load}, 32'd1);
        checkOutput("start_run_low", {31'd0, run}, 32'd0);
        cycle(1);
        checkOutput("start_run", {31'd0, run}, 32'd1);
        checkOutput("start_load_low", {31'd0, load}, 32'd0);

        // Pause and watch the blink cadence.
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checkOutput("pause_run", {31'd0, run}, 32'd0);
            checkOutput($sformatf("pause_blink%0d", i), {31'd0, blink}, ((i / 4) % 2));
            cycle(1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("pause_done_ignored_alarm", {31'd0, alarm}, 32'd0);
        checkOutput("pause_done_ignored_run", {31'd0, run}, 32'd0);

        // Resume.
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("resume_run", {31'd0, run}, 32'd1);
        checkOutput("resume_blink", {31'd0, blink}, 32'd0);

        // Lever and button together: skip wins.
        expectLoad(8'h05, 2'd2, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("skip_load", {31'd0, load}, 32'd1);
        checkOutput("skip_run_low", {31'd0, run}, 32'd0);
        cycle(1);
        checkOutput("skip_run", {31'd0, run}, 32'd1);

        // Short break completes; acknowledge with lever.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("brk_alarm", {31'd0, alarm}, 32'd1);
        checkOutput("brk_pomo", {29'd0, pomo_count}, 32'd0);
        cycle(2);
        expectLoad(8'h25, 2'd1, 3'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ack_alarm_low", {31'd0, alarm}, 32'd0);
        checkOutput("ack_load", {31'd0, load}, 32'd1);
        cycle(1);
        checkOutput("ack_run", {31'd0, run}, 32'd1);

        // Work completes with a simultaneous lever: done wins, alarm expires unattended.
        expectLoad(8'h05, 2'd2, 3'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("done1_pomo", {29'd0, pomo_count}, 32'd1);
        checkOutput("done1_run", {31'd0, run}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("alarm_hi%0d", i), {31'd0, alarm}, 32'd1);
            checkOutput($sformatf("alarm_blink%0d", i), {31'd0, blink}, ((i / 4) % 2));
            cycle(1);
        end
        checkOutput("expiry_alarm_low", {31'd0, alarm}, 32'd0);
        checkOutput("expiry_load", {31'd0, load}, 32'd1);
        cycle(1);
`ifdef POMO_AUTO_START_EN
        checkOutput("expiry_autostart_run", {31'd0, run}, 32'd1);
`else
        checkOutput("expiry_wait_run", {31'd0, run}, 32'd0);
        cycle(3);
        checkOutput("expiry_still_wait", {31'd0, run}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("expiry_resume_run", {31'd0, run}, 32'd1);
`endif

        // Short break completes; acknowledge with button.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("brk2_alarm", {31'd0, alarm}, 32'd1);
        expectLoad(8'h25, 2'd1, 3'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("ack2_alarm_low", {31'd0, alarm}, 32'd0);
        cycle(1);
        checkOutput("ack2_run", {31'd0, run}, 32'd1);

        // Second work completion earns the long break.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("done2_pomo", {29'd0, pomo_count}, 32'd2);
        expectLoad(8'h15, 2'd3, 3'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("long_phase", {30'd0, phase}, 32'd3);
        checkOutput("long_pomo", {29'd0, pomo_count}, 32'd0);
        cycle(1);
        checkOutput("long_run", {31'd0, run}, 32'd1);

        // Asynchronous reset mid-run, between clock edges.
        cycle(2);
        rst = 1'b1;
        #1;
        checkResetState("async_rst");
        cycle(2);
        rst = 1'b0;
        cycle(2);
        checkOutput("post_rst_run", {31'd0, run}, 32'd0);

        checkOutput("scoreboard_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
